deconv_engine: RTL and testbench

//  Inverse of the 8x8 linear convolver: given convolution output Y and kernel H, recovers input S by

---
 rtl/conv_pkg.sv | 30 +++
 rtl/deconv_div.sv | 74 +++++++
 rtl/deconv_engine.sv | 147 ++++++++++++++
 tb/tb_deconv_engine.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and sizes for the convolver / deconvolver pair.
package conv_pkg;

   localparam int unsigned N    = 8;
   localparam int unsigned DW   = 8;
   localparam int unsigned YW   = 16;
   localparam int unsigned ACCW = 20;

   typedef logic [DW-1:0]          sample_t;
   typedef logic [YW-1:0]          yword_t;
   typedef logic signed [ACCW-1:0] acc_t;

   typedef enum logic [2:0] {
      StIdle,
      StChk,
      StMac,
      StSub,
      StDiv,
      StWr,
      StFin
   } deconv_state_t;

   // Unsigned DW x DW product, zero-extended into the signed accumulator.
   function automatic acc_t mac_term(sample_t h, sample_t s);
      logic [2*DW-1:0] p;
      p = h * s;
      return acc_t'({{(ACCW-2*DW){1'b0}}, p});
   endfunction

endpackage

// File: rtl/deconv_div.sv
// Restoring divider: YW-bit dividend by DW-bit divisor, one quotient bit per cycle.
// start loads operands; done is high in the cycle whose closing edge retires the last bit,
// so quotient/remainder are final from the following cycle and hold until the next start.
module deconv_div
   import conv_pkg::*;
(
   input  logic          clk,
   input  logic          rstn,
   input  logic          start,
   input  logic [YW-1:0] dividend,
   input  logic [DW-1:0] divisor,
   output logic [YW-1:0] quotient,
   output logic [DW-1:0] remainder,
   output logic          done
);

   localparam int unsigned CNTW = $clog2(YW);
   localparam logic [CNTW-1:0] CntLast = CNTW'(YW - 1);

   logic [YW-1:0]   quo_q, quo_d;
   logic [DW-1:0]   rem_q, rem_d;
   logic [DW-1:0]   dvs_q, dvs_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic            run_q, run_d;
   logic [DW:0]     trial;
   logic [DW-1:0]   diff;
   logic            ge;

   // One shift-subtract step per cycle; remainder stays below the divisor so DW bits suffice.
   always_comb begin
      trial = {rem_q, quo_q[YW-1]};
      ge    = trial >= {1'b0, dvs_q};
      diff  = trial[DW-1:0] - dvs_q;
      quo_d = quo_q;
      rem_d = rem_q;
      dvs_d = dvs_q;
      cnt_d = cnt_q;
      run_d = run_q;
      if (start) begin
         quo_d = dividend;
         rem_d = '0;
         dvs_d = divisor;
         cnt_d = '0;
         run_d = 1'b1;
      end else if (run_q) begin
         quo_d = {quo_q[YW-2:0], ge};
         rem_d = ge ? diff : trial[DW-1:0];
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == CntLast) run_d = 1'b0;
      end
   end

   // Divider state registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         quo_q <= '0;
         rem_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else begin
         quo_q <= quo_d;
         rem_q <= rem_d;
         dvs_q <= dvs_d;
         cnt_q <= cnt_d;
         run_q <= run_d;
      end
   end

   assign quotient  = quo_q;
   assign remainder = rem_q;
   assign done      = run_q && (cnt_q == CntLast);

endmodule

// File: rtl/deconv_engine.sv
// Deconvolver: recovers S from Y = S * H by sequential long division, one MAC per cycle.
module deconv_engine
   import conv_pkg::*;
(
   input  logic                   clk,
   input  logic                   rstn,
   input  logic [2*N-2:0][YW-1:0] Y,
   input  logic [N-1:0][DW-1:0]   H,
   input  logic                   start,
   output logic [N-1:0][DW-1:0]   S,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);

   localparam int unsigned CW = $clog2(N);
   localparam logic [CW-1:0] NLast = CW'(N - 1);

   deconv_state_t             state_q, state_d;
   logic [CW-1:0]             n_q, n_d, k_q, k_d;
   acc_t                      acc_q, acc_d;
   logic [N-1:0][YW-1:0]      y_q, y_d;
   logic [N-1:0][DW-1:0]      h_q, h_d, s_q, s_d;
   logic                      err_q, err_d;
   logic                      div_start, div_done;
   logic [YW-1:0]             div_quo;
   logic [DW-1:0]             div_rem;
   acc_t                      resid;
   logic [CW-1:0]             s_idx;
   logic                      unused_y_tail;

   // The upper half of Y is redundant for recovery and deliberately not examined.
   assign unused_y_tail = ^Y[2*N-2:N];

   assign resid = acc_t'({{(ACCW-YW){1'b0}}, y_q[n_q]}) - acc_q;
   assign s_idx = n_q - k_q;

   deconv_div u_div (
      .clk       (clk),
      .rstn      (rstn),
      .start     (div_start),
      .dividend  (resid[YW-1:0]),
      .divisor   (h_q[0]),
      .quotient  (div_quo),
      .remainder (div_rem),
      .done      (div_done)
   );

   // Sequencer: CHK, then per sample MAC/SUB/DIV/WR, then FIN; any error jumps to FIN.
   always_comb begin
      state_d   = state_q;
      n_d       = n_q;
      k_d       = k_q;
      acc_d     = acc_q;
      y_d       = y_q;
      h_d       = h_q;
      s_d       = s_q;
      err_d     = err_q;
      div_start = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               y_d     = Y[N-1:0];
               h_d     = H;
               s_d     = '0;
               err_d   = 1'b0;
               state_d = StChk;
            end
         end
         StChk: begin
            n_d   = '0;
            k_d   = CW'(1);
            acc_d = '0;
            if (h_q[0] == '0) begin
               err_d   = 1'b1;
               state_d = StFin;
            end else begin
               state_d = StSub;   // n = 0 has no MAC terms
            end
         end
         StMac: begin
            acc_d = acc_q + mac_term(h_q[k_q], s_q[s_idx]);
            if (k_q == n_q) state_d = StSub;
            else            k_d     = k_q + 1'b1;
         end
         StSub: begin
            if (resid[ACCW-1] || (|resid[ACCW-2:YW])) begin
               err_d   = 1'b1;
               state_d = StFin;
            end else begin
               div_start = 1'b1;
               state_d   = StDiv;
            end
         end
         StDiv: begin
            if (div_done) state_d = StWr;
         end
         StWr: begin
            if ((div_rem != '0) || (|div_quo[YW-1:DW])) begin
               err_d   = 1'b1;
               state_d = StFin;
            end else begin
               s_d[n_q] = div_quo[DW-1:0];
               if (n_q == NLast) begin
                  state_d = StFin;
               end else begin
                  n_d     = n_q + 1'b1;
                  k_d     = CW'(1);
                  acc_d   = '0;
                  state_d = StMac;
               end
            end
         end
         StFin:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Engine state registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= StIdle;
         n_q     <= '0;
         k_q     <= '0;
         acc_q   <= '0;
         y_q     <= '0;
         h_q     <= '0;
         s_q     <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         k_q     <= k_d;
         acc_q   <= acc_d;
         y_q     <= y_d;
         h_q     <= h_d;
         s_q     <= s_d;
         err_q   <= err_d;
      end
   end

   assign S    = s_q;
   assign busy = (state_q != StIdle);
   assign done = (state_q == StFin);
   assign err  = err_q;

endmodule

// File: tb/tb_deconv_engine.sv
// Scoreboard bench for deconv_engine: expectations queued at launch, checked at done.
module tb_deconv_engine;
   import conv_pkg::*;

   logic                   clk = 1'b0;
   logic                   rstn;
   logic [2*N-2:0][YW-1:0] Y;
   logic [N-1:0][DW-1:0]   H;
   logic                   start;
   logic [N-1:0][DW-1:0]   S;
   logic                   busy, done, err;

   always #5 clk = ~clk;

   deconv_engine dut (
      .clk   (clk),
      .rstn  (rstn),
      .Y     (Y),
      .H     (H),
      .start (start),
      .S     (S),
      .busy  (busy),
      .done  (done),
      .err   (err)
   );

   typedef struct {
      logic [N-1:0][DW-1:0] s;
      logic                 err;
      int                   lat;
      int                   id;
   } exp_t;

   exp_t sb[$];
   int   vec_cnt  = 0;
   int   miss_cnt = 0;

   // Drive one request and queue its expectation; returns at the falling edge of cycle 1.
   task automatic launch(input logic [N-1:0][YW-1:0] y, input logic [N-1:0][DW-1:0] h,
                         input exp_t e);
      @(negedge clk);
      Y[N-1:0]     = y;
      Y[2*N-2:N]   = {(N-1){16'hBEEF}};
      H            = h;
      start        = 1'b1;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      Y     = '1;     // inputs after accept must not matter
      H     = '0;
   endtask

   // Bounded wait for done; cyc is the cycle number counted from the accept edge.
   task automatic wait_done(output int cyc, output logic seen);
      cyc  = 1;
      seen = 1'b0;
      while (cyc < 400) begin
         if (done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset();
      rstn  = 1'b0;
      start = 1'b0;
      Y     = '0;
      H     = '0;
      repeat (3) @(negedge clk);
      vec_cnt++;
      if ({S, busy, done, err} !== '0) begin
         miss_cnt++;
         $display("FAIL reset: S=%h busy=%b done=%b err=%b, required all zero", S, busy, done, err);
      end
      rstn = 1'b1;
      @(negedge clk);
      vec_cnt++;
      if ({S, busy, done, err} !== '0) begin
         miss_cnt++;
         $display("FAIL post_reset: S=%h busy=%b done=%b err=%b, required all zero",
                  S, busy, done, err);
      end
   endtask

   task automatic test_clean();
      logic [N-1:0][YW-1:0] y;
      logic [N-1:0][DW-1:0] h;
      exp_t e, got;
      int   cyc;
      logic seen;
      for (int i = 0; i < N; i++) h[i] = 8'd3;
      y = {16'd108, 16'd84, 16'd63, 16'd45, 16'd30, 16'd18, 16'd9, 16'd3};
      e.s   = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
      e.err = 1'b0;
      e.lat = 174;
      e.id  = 1;
      launch(y, h, e);
      wait_done(cyc, seen);
      got = sb.pop_front();
      vec_cnt++;
      if (!seen) begin
         miss_cnt++;
         $display("FAIL case%0d_timeout: done not seen, required at cycle %0d", got.id, got.lat);
      end else begin
         vec_cnt += 4;
         if (cyc !== got.lat) begin
            miss_cnt++;
            $display("FAIL case%0d_latency: got %0d, required %0d", got.id, cyc, got.lat);
         end
         if (err !== got.err) begin
            miss_cnt++;
            $display("FAIL case%0d_err: got %b, required %b", got.id, err, got.err);
         end
         if (S !== got.s) begin
            miss_cnt++;
            $display("FAIL case%0d_S: got %h, required %h", got.id, S, got.s);
         end
         if (busy !== 1'b1) begin
            miss_cnt++;
            $display("FAIL case%0d_busy_at_done: got %b, required 1", got.id, busy);
         end
      end
      @(negedge clk);
      vec_cnt++;
      if (busy !== 1'b0 || done !== 1'b0 || err !== got.err) begin
         miss_cnt++;
         $display("FAIL case%0d_after_done: busy=%b done=%b err=%b, required 0 0 %b",
                  got.id, busy, done, err, got.err);
      end
   endtask

   // Identity kernel, then a first sample too large for DW bits.
   task automatic test_identity();
      logic [N-1:0][YW-1:0] y;
      logic [N-1:0][DW-1:0] h;
      exp_t e, got;
      int   cyc;
      logic seen;
      for (int pass = 0; pass < 2; pass++) begin
         h    = '0;
         h[0] = 8'd1;
         for (int i = 0; i < N; i++) y[i] = YW'(i);
         e.id = 30 + pass;
         if (pass == 0) begin
            for (int i = 0; i < N; i++) e.s[i] = DW'(i);
            e.err = 1'b0;
            e.lat = 174;
         end else begin
            y[0]  = 16'd512;
            e.s   = '0;
            e.err = 1'b1;
            e.lat = 20;
         end
         launch(y, h, e);
         wait_done(cyc, seen);
         got = sb.pop_front();
         vec_cnt++;
         if (!seen) begin
            miss_cnt++;
            $display("FAIL case%0d_timeout: done not seen, required at cycle %0d", got.id, got.lat);
         end else begin
            vec_cnt += 3;
            if (cyc !== got.lat) begin
               miss_cnt++;
               $display("FAIL case%0d_latency: got %0d, required %0d", got.id, cyc, got.lat);
            end
            if (err !== got.err) begin
               miss_cnt++;
               $display("FAIL case%0d_err: got %b, required %b", got.id, err, got.err);
            end
            if (S !== got.s) begin
               miss_cnt++;
               $display("FAIL case%0d_S: got %h, required %h", got.id, S, got.s);
            end
         end
         @(negedge clk);
      end
   endtask

   // H[0]=0, nonzero remainder, negative residual.
   task automatic test_errors();
      logic [N-1:0][YW-1:0] y;
      logic [N-1:0][DW-1:0] h;
      exp_t e, got;
      int   cyc;
      logic seen;
      for (int c = 0; c < 3; c++) begin
         y     = '0;
         h     = '0;
         e.s   = '0;
         e.err = 1'b1;
         case (c)
            0: begin
               h[1] = 8'd3; y[0] = 16'd5; e.lat = 2; e.id = 2;
            end
            1: begin
               h[0] = 8'd3; y[0] = 16'd4; e.lat = 20; e.id = 4;
            end
            default: begin
               h[0] = 8'd1; h[1] = 8'd5; y[0] = 16'd1; y[1] = 16'd2;
               e.s[0] = 8'd1; e.lat = 22; e.id = 5;
            end
         endcase
         launch(y, h, e);
         wait_done(cyc, seen);
         got = sb.pop_front();
         vec_cnt++;
         if (!seen) begin
            miss_cnt++;
            $display("FAIL case%0d_timeout: done not seen, required at cycle %0d", got.id, got.lat);
         end else begin
            vec_cnt += 3;
            if (cyc !== got.lat) begin
               miss_cnt++;
               $display("FAIL case%0d_latency: got %0d, required %0d", got.id, cyc, got.lat);
            end
            if (err !== got.err) begin
               miss_cnt++;
               $display("FAIL case%0d_err: got %b, required %b", got.id, err, got.err);
            end
            if (S !== got.s) begin
               miss_cnt++;
               $display("FAIL case%0d_S: got %h, required %h", got.id, S, got.s);
            end
         end
         @(negedge clk);
      end
   endtask

   // Random S and H, Y formed by forward convolution; S must come back exactly.
   task automatic test_roundtrip();
      logic [N-1:0][YW-1:0] y;
      logic [N-1:0][DW-1:0] h;
      exp_t e, got;
      int   cyc, acc;
      logic seen;
      for (int t = 0; t < 4; t++) begin
         for (int i = 0; i < N; i++) begin
            e.s[i] = DW'($urandom_range(0, 31));
            h[i]   = DW'($urandom_range((i == 0) ? 1 : 0, 31));
         end
         for (int n = 0; n < N; n++) begin
            acc = 0;
            for (int k = 0; k <= n; k++) acc += int'(h[k]) * int'(e.s[n-k]);
            y[n] = YW'(acc);
         end
         e.err = 1'b0;
         e.lat = 174;
         e.id  = 100 + t;
         launch(y, h, e);
         wait_done(cyc, seen);
         got = sb.pop_front();
         vec_cnt++;
         if (!seen) begin
            miss_cnt++;
            $display("FAIL case%0d_timeout: done not seen, required at cycle %0d", got.id, got.lat);
         end else begin
            vec_cnt += 2;
            if (err !== got.err || cyc !== got.lat) begin
               miss_cnt++;
               $display("FAIL case%0d_err_lat: got err=%b cyc=%0d, required err=%b cyc=%0d",
                        got.id, err, cyc, got.err, got.lat);
            end
            if (S !== got.s) begin
               miss_cnt++;
               $display("FAIL case%0d_S: got %h, required %h", got.id, S, got.s);
            end
         end
         @(negedge clk);
      end
   endtask

   // Ignored restart while busy, asynchronous abort, then a clean rerun.
   task automatic test_abort();
      logic [N-1:0][YW-1:0] y;
      logic [N-1:0][DW-1:0] h;
      exp_t e, got;
      int   cyc;
      logic seen, early_done;
      for (int i = 0; i < N; i++) h[i] = 8'd3;
      y = {16'd108, 16'd84, 16'd63, 16'd45, 16'd30, 16'd18, 16'd9, 16'd3};
      e.s   = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
      e.err = 1'b0;
      e.lat = 174;
      e.id  = 6;
      launch(y, h, e);
      early_done = 1'b0;
      for (int c = 1; c < 60; c++) begin
         if (c == 30) begin
            H     = '0;   // would fail at CHK if this start were accepted
            start = 1'b1;
         end
         if (c == 31) start = 1'b0;
         if (c > 30 && (done !== 1'b0 || busy !== 1'b1)) early_done = 1'b1;
         @(negedge clk);
      end
      vec_cnt++;
      if (early_done) begin
         miss_cnt++;
         $display("FAIL case6_ignored_start: done/busy disturbed by start while busy, required none");
      end
      got  = sb.pop_front();   // aborted run produces no result
      rstn = 1'b0;
      #1;
      vec_cnt++;
      if ({S, busy, done, err} !== '0) begin
         miss_cnt++;
         $display("FAIL case6_async_abort: S=%h busy=%b done=%b err=%b, required all zero",
                  S, busy, done, err);
      end
      early_done = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (done !== 1'b0) early_done = 1'b1;
      end
      rstn = 1'b1;
      vec_cnt++;
      if (early_done) begin
         miss_cnt++;
         $display("FAIL case6_no_done_in_reset: done pulsed during reset, required 0");
      end
      launch(y, h, e);
      wait_done(cyc, seen);
      got = sb.pop_front();
      vec_cnt++;
      if (!seen) begin
         miss_cnt++;
         $display("FAIL case6_restart_timeout: done not seen, required at cycle %0d", got.lat);
      end else begin
         vec_cnt++;
         if (cyc !== got.lat || err !== got.err || S !== got.s) begin
            miss_cnt++;
            $display("FAIL case6_restart: got cyc=%0d err=%b S=%h, required cyc=%0d err=%b S=%h",
                     cyc, err, S, got.lat, got.err, got.s);
         end
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_clean();
      test_identity();
      test_errors();
      test_roundtrip();
      test_abort();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
